// File: rtl/stream_mux.sv
// Packet multiplexer: an accepted select locks one input channel until its last beat is taken.
// Registered output stage: one cycle from input acceptance to out_valid, one beat/cycle while out_ready stays high.
module stream_mux #(
   parameter int WIDTH = 2,
   parameter int N_IN  = 4,
   parameter int SEL_W = $clog2(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [N_IN-1:0]       in_valid,
   input  logic [N_IN-1:0]       in_last,
   output logic [N_IN-1:0]       in_ready,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  sel_valid,
   output logic                  sel_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      cur_sel,
   output logic                  busy,
   output logic                  sel_err
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state, state_nxt;
   logic             sel_ok, lock, bad_sel, take, room;
   logic [WIDTH-1:0] ch_data;
   logic             ch_valid, ch_last;

   assign sel_ok = 32'(sel) < N_IN;
   assign room   = ~out_valid | out_ready;

   always_comb begin
      ch_data  = '0;
      ch_valid = 1'b0;
      ch_last  = 1'b0;
      for (int i = 0; i < N_IN; i++) begin
         if (cur_sel == SEL_W'(i)) begin
            ch_data  = in_data[i*WIDTH +: WIDTH];
            ch_valid = in_valid[i];
            ch_last  = in_last[i];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      sel_ready = 1'b0;
      busy      = 1'b0;
      lock      = 1'b0;
      bad_sel   = 1'b0;
      take      = 1'b0;
      in_ready  = '0;
      case (state)
         IDLE: begin
            sel_ready = 1'b1;
            if (sel_valid) begin
               if (sel_ok) begin
                  lock      = 1'b1;
                  state_nxt = LOCKED;
               end else begin
                  bad_sel = 1'b1;
               end
            end
         end
         LOCKED: begin
            busy = 1'b1;
            for (int i = 0; i < N_IN; i++) begin
               if (cur_sel == SEL_W'(i)) in_ready[i] = room;
            end
            take = ch_valid & room;
            // The last beat may still be held in the output register; it drains on its own.
            if (take & ch_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_sel <= '0;
         sel_err <= 1'b0;
      end else begin
         sel_err <= bad_sel;
         if (lock) cur_sel <= sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (take) begin
         out_valid <= 1'b1;
         out_data  <= ch_data;
         out_last  <= ch_last;
      end else if (out_ready & out_valid) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux (5 channels, 8-bit data): per-cycle check against a beat-level model,
// plus literal expectations on the delivered beat sequences and their cycle spacing.
module tb_stream_mux;
   localparam int W  = 8;
   localparam int N  = 5;
   localparam int SW = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid, in_last, in_ready;
   logic [SW-1:0]  sel;
   logic           sel_valid, sel_ready;
   logic [W-1:0]   out_data;
   logic           out_valid, out_last, out_ready;
   logic [SW-1:0]  cur_sel;
   logic           busy, sel_err;

   stream_mux #(.WIDTH(W), .N_IN(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .sel(sel), .sel_valid(sel_valid), .sel_ready(sel_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .cur_sel(cur_sel), .busy(busy), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, cyc_cnt = 0;

   // stimulus sources: per-channel beat lists {last, data} and a select list
   logic [8:0] src_mem [N][64];
   int         src_head [N];
   int         src_tail [N];
   int         sel_mem [16];
   int         sel_head = 0, sel_tail = 0;
   int         ordy_mode = 0, ordy_cnt = 0;

   // beats seen leaving the DUT
   int log_dat [64];
   int log_lst [64];
   int log_cyc [64];
   int log_n = 0, err_cnt = 0;

   // model: locked channel, one held output beat
   logic       m_locked, m_hv, m_hl, m_err;
   int         m_ch;
   logic [7:0] m_hd;
   logic       prev_stall = 1'b0;
   logic [8:0] prev_bits;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
      else n_pass++;
   endtask

   task automatic push_beat(input int ch, input int d, input logic l);
      src_mem[ch][src_tail[ch]] = {l, 8'(d)};
      src_tail[ch]++;
   endtask

   task automatic push_sel(input int s);
      sel_mem[sel_tail] = s;
      sel_tail++;
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      @(posedge clk);
      while (!(sel_head == sel_tail && !m_locked && !m_hv) && k < 60) begin
         @(posedge clk);
         k++;
      end
      if (k >= 60) begin
         n_chk++;
         $display("FAIL %s: no completion within %0d cycles, required drained and unlocked", name, k);
      end
   endtask

   always begin : drive_and_check
      logic [N-1:0] exp_rdy;
      logic         acc, was_locked;
      int           sv;
      @(negedge clk);
      #1;
      cyc_cnt++;
      case (ordy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (ordy_cnt % 3 == 0);
         default: out_ready = 1'b0;
      endcase
      ordy_cnt++;
      for (int i = 0; i < N; i++) begin
         if (src_head[i] != src_tail[i]) begin
            in_valid[i]         = 1'b1;
            in_data[i*W +: W]   = src_mem[i][src_head[i]][7:0];
            in_last[i]          = src_mem[i][src_head[i]][8];
         end else begin
            in_valid[i]         = 1'b0;
            in_data[i*W +: W]   = 8'hE0 + 8'(i);
            in_last[i]          = 1'b0;
         end
      end
      sv        = (sel_head != sel_tail) ? sel_mem[sel_head] : 0;
      sel_valid = (sel_head != sel_tail);
      sel       = SW'(sv);
      #1;
      if (!rst_n) begin
         m_locked = 0; m_ch = 0; m_hv = 0; m_hd = '0; m_hl = 0; m_err = 0;
         prev_stall = 0;
      end
      exp_rdy = '0;
      if (m_locked && (!m_hv || out_ready)) exp_rdy[m_ch] = 1'b1;
      chk("out_valid", 32'(out_valid), 32'(m_hv));
      chk("out_data", 32'(out_data), 32'(m_hd));
      chk("out_last", 32'(out_last), 32'(m_hl));
      chk("busy", 32'(busy), 32'(m_locked));
      chk("sel_ready", 32'(sel_ready), 32'(!m_locked));
      chk("cur_sel", 32'(cur_sel), 32'(m_ch));
      chk("sel_err", 32'(sel_err), 32'(m_err));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (rst_n) begin
         if (prev_stall) chk("stall_hold", 32'({out_last, out_data}), 32'(prev_bits));
         prev_stall = out_valid && !out_ready;
         prev_bits  = {out_last, out_data};
         if (out_valid && out_ready && log_n < 64) begin
            log_dat[log_n] = int'(out_data);
            log_lst[log_n] = int'(out_last);
            log_cyc[log_n] = cyc_cnt;
            log_n++;
         end
         if (sel_err) err_cnt++;
         was_locked = m_locked;
         acc = m_locked && in_valid[m_ch] && exp_rdy[m_ch];
         m_err = !was_locked && sel_valid && sv >= N;
         if (acc) begin
            m_hv = 1'b1;
            m_hd = src_mem[m_ch][src_head[m_ch]][7:0];
            m_hl = src_mem[m_ch][src_head[m_ch]][8];
            src_head[m_ch]++;
            if (m_hl) m_locked = 1'b0;
         end else if (m_hv && out_ready) begin
            m_hv = 1'b0;
         end
         if (!was_locked && sel_valid) begin
            sel_head++;
            if (sv < N) begin
               m_locked = 1'b1;
               m_ch     = sv;
            end
         end
      end
   end

   initial begin : stimulus
      int t0, n3;
      for (int i = 0; i < N; i++) begin
         src_head[i] = 0;
         src_tail[i] = 0;
      end
      rst_n = 1'b0; in_valid = '0; in_last = '0; in_data = '0;
      sel = '0; sel_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // single packet on channel 2
      log_n = 0; t0 = cyc_cnt + 1;
      push_sel(2); push_beat(2, 1, 0); push_beat(2, 2, 0); push_beat(2, 3, 1);
      wait_drain("single");
      chk("single_count", 32'(log_n), 3);
      chk("single_d0", 32'(log_dat[0]), 1);
      chk("single_d1", 32'(log_dat[1]), 2);
      chk("single_d2", 32'(log_dat[2]), 3);
      chk("single_lasts", 32'({log_lst[0][0], log_lst[1][0], log_lst[2][0]}), 32'b001);
      chk("single_latency", 32'(log_cyc[0] - t0), 2);
      chk("single_gap01", 32'(log_cyc[1] - log_cyc[0]), 1);
      chk("single_gap12", 32'(log_cyc[2] - log_cyc[1]), 1);

      // channel 1 holds a beat while channel 0 is locked
      log_n = 0;
      push_beat(1, 3, 1);
      push_sel(0); push_beat(0, 8'hA, 0); push_beat(0, 8'hB, 1);
      wait_drain("isolation");
      n3 = 0;
      for (int i = 0; i < log_n; i++) if (log_dat[i] == 3) n3++;
      chk("iso_count", 32'(log_n), 2);
      chk("iso_no_ch1", 32'(n3), 0);
      chk("iso_d0", 32'(log_dat[0]), 32'hA);
      chk("iso_d1", 32'(log_dat[1]), 32'hB);
      src_head[1] = src_tail[1];

      // backpressure pattern 1,0,0 on channel 1
      log_n = 0; ordy_mode = 1; ordy_cnt = 0;
      push_sel(1);
      push_beat(1, 8'h11, 0); push_beat(1, 8'h22, 0); push_beat(1, 8'h33, 0); push_beat(1, 8'h44, 1);
      wait_drain("backpressure");
      ordy_mode = 0;
      chk("bp_count", 32'(log_n), 4);
      chk("bp_d0", 32'(log_dat[0]), 32'h11);
      chk("bp_d1", 32'(log_dat[1]), 32'h22);
      chk("bp_d2", 32'(log_dat[2]), 32'h33);
      chk("bp_d3", 32'(log_dat[3]), 32'h44);
      chk("bp_last", 32'(log_lst[3]), 1);

      // out-of-range selects 7 and 5, then a valid select 1
      log_n = 0; err_cnt = 0;
      push_sel(7); push_sel(5); push_sel(1); push_beat(1, 8'h05, 1);
      wait_drain("bad_sel");
      chk("bad_err_cycles", 32'(err_cnt), 2);
      chk("bad_count", 32'(log_n), 1);
      chk("bad_d0", 32'(log_dat[0]), 32'h05);

      // back-to-back packets: channel 3 then channel 0
      log_n = 0;
      push_sel(3); push_sel(0);
      push_beat(3, 8'h31, 0); push_beat(3, 8'h32, 1);
      push_beat(0, 8'h01, 0); push_beat(0, 8'h02, 1);
      wait_drain("b2b");
      chk("b2b_count", 32'(log_n), 4);
      chk("b2b_seq", 32'({8'(log_dat[0]), 8'(log_dat[1]), 8'(log_dat[2]), 8'(log_dat[3])}), 32'h31320102);
      chk("b2b_gap_in", 32'(log_cyc[1] - log_cyc[0]), 1);
      chk("b2b_gap_switch", 32'(log_cyc[2] - log_cyc[1]), 2);

      // reset mid-packet with a stalled beat held at the output
      log_n = 0; ordy_mode = 2;
      push_sel(4); push_beat(4, 8'h41, 0); push_beat(4, 8'h42, 0); push_beat(4, 8'h43, 1);
      repeat (4) @(posedge clk);
      #3;
      chk("pre_rst_out_valid", 32'(out_valid), 1);
      chk("pre_rst_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sel_ready", 32'(sel_ready), 1);
      chk("rst_in_ready", 32'(in_ready), 0);
      for (int i = 0; i < N; i++) src_head[i] = src_tail[i];
      sel_head = sel_tail; ordy_mode = 0; log_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_no_beats", 32'(log_n), 0);
      chk("post_rst_out_valid", 32'(out_valid), 0);
      chk("post_rst_busy", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/stream_mux.md
Name: stream_mux

Overview:
- N-input, WIDTH-bit packet multiplexer with valid/ready handshakes on every channel and a registered output stage.
- A channel select is accepted over its own handshake and is locked for one whole packet. The lock releases only after the beat marked last has been accepted.
- Used where several datapath sources share one downstream consumer and packets must not interleave.

Parameters:
- WIDTH, 2, data bits per beat.
- N_IN, 4, number of input channels (2..16).
- SEL_W, $clog2(N_IN), width of select fields.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_IN  per-channel beat valid.
- in_last  input  N_IN  per-channel end-of-packet flag, qualified by in_valid.
- in_ready  output  N_IN  per-channel ready.
- sel  input  SEL_W  requested channel.
- sel_valid  input  1  select request.
- sel_ready  output  1  select accepted when high together with sel_valid.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last.
- out_ready  input  1  downstream ready.
- cur_sel  output  SEL_W  currently locked channel.
- busy  output  1  high while in LOCKED.
- sel_err  output  1  one-cycle pulse on an out-of-range select.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; out_valid=0, out_data=0, out_last=0, cur_sel=0, sel_err=0, busy=0. Reset asserted mid-packet discards the held beat and the lock; no partial packet completes afterwards.
- States: IDLE, LOCKED.
- IDLE:
  - sel_ready=1 and all in_ready=0.
  - On sel_valid with sel<N_IN: cur_sel<=sel, go to LOCKED next cycle.
  - On sel_valid with sel>=N_IN: the request is consumed, sel_err pulses high for one cycle, and the state stays IDLE.
- LOCKED:
  - sel_ready=0; busy=1.
  - in_ready[cur_sel] = ~out_valid | out_ready (combinational). All other in_ready=0.
- Output stage:
  - Loads when in_valid[cur_sel] & in_ready[cur_sel]: out_data<=in_data[cur_sel], out_last<=in_last[cur_sel], out_valid<=1.
  - Otherwise, if out_ready & out_valid, out_valid<=0.
  - Latency is 1 cycle from input acceptance to out_valid.
  - Full throughput is 1 beat/cycle while out_ready=1.
- Release: when the accepted input beat has in_last=1, the next state is IDLE. The last beat may still sit in the output register; it drains independently.
- Back-to-back packets: the cycle after release is IDLE, and a new select can be accepted that same cycle. The new channel sees in_ready from the following cycle, so there is one idle input cycle between packets.
- Stalls:
  - out_valid=1 and out_ready=0: out_data, out_last and out_valid hold, and in_ready[cur_sel]=0.
  - out_valid, out_data and out_last never change while out_valid=1 & out_ready=0.
- Inputs other than cur_sel are ignored. Their valid may stay high indefinitely without effect.
- Data is never dropped, duplicated or reordered. Out-of-range select indices never lock.

Test Plan:
- Reset: drive rst_n=0 mid-packet with out_valid=1 -> out_valid=0, busy=0, sel_ready=1 immediately (asynchronously), all in_ready=0.
- Single packet: sel=2 accepted; channel 2 sends 0x1,0x2,0x3 (last on 0x3) with out_ready=1 -> out_data 1,2,3 on consecutive cycles starting one cycle after the first acceptance; out_last=1 only with 0x3; busy drops the cycle after the 0x3 acceptance.
- Isolation: lock channel 0 while channel 1 holds valid=1 with data 0x3 -> in_ready[1]=0 throughout; no 0x3 appears on out_data.
- Backpressure: stream 4 beats from channel 1 while out_ready toggles 1,0,0,1,... -> output sequence is identical to the input with no loss or duplication, and out_data is stable during every stall.
- Bad select: N_IN=4, sel=5 (SEL_W=3 build with N_IN=5 variant, sel=7) -> sel_err pulses for 1 cycle; state stays IDLE; a following sel=1 locks normally.
- Back-to-back: packet on ch3 (2 beats), then sel=0 presented the cycle after last is accepted -> ch0's first beat is accepted 2 cycles after ch3's last; the output shows no interleaving.
